feature_mac_classifier: RTL and testbench
=========================================

Name: feature_mac_classifier

Overview:
- Parametrised successor of the single-output feature engine: buffers N_FEAT signed features, holds per-class weight vectors, and computes N_CLASSES dot products with one multiply-accumulate per cycle.
- Produces the winning class index (argmax) and its score.
- Sits between the feature-extraction front end (indexed feature writes) and the decision logic (done/result consumer).

Parameters:
- N_FEAT, 136, number of features per inference
- DATA_W, 8, feature and weight width, signed two's complement
- N_CLASSES, 4, number of weight vectors / output scores
- IDX_W, $clog2(N_FEAT), feature index width
- CLS_W, $clog2(N_CLASSES) (min 1), class index width
- ACC_W, 2*DATA_W+$clog2(N_FEAT), accumulator width; no overflow possible at defaults

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- feat_wr  in  1  write strobe, feature buffer
- feat_index  in  IDX_W  feature address
- feat_data  in  DATA_W  signed feature value
- wt_wr  in  1  write strobe, weight buffer
- wt_class  in  CLS_W  weight class address
- wt_index  in  IDX_W  weight feature address
- wt_data  in  DATA_W  signed weight value
- start  in  1  begin inference (1-cycle pulse, or held)
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  1-cycle pulse, result valid
- out_class  out  CLS_W  argmax class, held until next done
- out_score  out  ACC_W  signed score of out_class, held
- load_err  out  1  sticky; set on out-of-range index/class write or write while busy; cleared by start

Behaviour:
- Reset (async, rst_n=0): FSM to IDLE; busy, done, load_err, out_class, out_score = 0; MAC pipeline cleared. Buffer contents are not reset (undefined until written).
- FSM states: IDLE -> RUN -> DRAIN -> FIN -> IDLE.
- IDLE:
  - feat_wr/wt_wr write buffers, one entry each per cycle; both may fire in the same cycle.
  - Index >= N_FEAT or class >= N_CLASSES: write dropped, load_err set.
  - start=1: clear load_err, reset counters, go to RUN. Writes in that same cycle still land.
- RUN:
  - Counter pair (cls, idx) steps idx 0..N_FEAT-1, then cls++; one operand read per cycle.
  - Stage 1 registers the signed product. Stage 2 accumulates it, sign-extended to ACC_W.
  - Accumulator is reloaded with the product on idx==0 of each class.
  - After the last (cls, idx), go to DRAIN.
- DRAIN: 2 cycles to flush the pipeline.
- Argmax: on each completed class sum, compare against the running best using a strict greater-than. Ties keep the lower class index. Class 0 always initialises best.
- FIN: register out_class/out_score, done=1 for exactly one cycle, busy=0, return to IDLE.
- Latency: start sampled at edge T0 -> done high after edge T0+N_CLASSES*N_FEAT+3. At defaults that is 547 cycles. busy is high for edges T0+1 .. T0+N_CLASSES*N_FEAT+2.
- Writes while busy: dropped, load_err set. Inference uses the buffer snapshot as of start.
- start while busy: ignored; no restart.
- start in the same cycle as done/FIN: not accepted. Accepted from the next IDLE cycle.
- rst_n low mid-RUN: immediate abort; outputs return to reset values; no done.
- Back-to-back inference without reloading: allowed; reuses buffer contents.

Decomposition:
- Package fmc_pkg: state enum (IDLE, RUN, DRAIN, FIN) and helper function for ACC_W/CLS_W width derivation.
- Sub-module fmc_mac_lane: 2-stage signed multiply-accumulate with clear-on-first input. Instantiated once; keeps the top module as FSM plus buffers.

Test Plan:
- All 136 features = 0x7f; class 0 weights = 0x01, classes 1-3 = 0x00; start -> done at start+547, out_class=0, out_score=17272 (0x4378).
- Features = 0x80 (-128); class 1 weights = 0x7f, class 2 = 0x80, others 0 -> out_class=2, out_score=2228224; class 1 internal sum -2210816 checked via hierarchical probe.
- Classes 1 and 3 weights identical and maximal, others 0, features 0x01 -> tie resolves to out_class=1.
- Write feat_index=136 and wt_class valid with wt_index=200 in IDLE -> both dropped, load_err=1; next start clears load_err=0.
- Start, pulse start again and feat_wr mid-RUN -> no restart, done at original start+547, load_err=1, result matches the pre-start buffer.
- Drop rst_n at cycle 100 of RUN -> busy=0, done never asserted, out_score=0; new start after release gives the correct result.

Source files
------------

// File: rtl/fmc_pkg.sv
// Shared types and width helpers for the feature MAC classifier.
package fmc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        FIN
    } fmc_state_t;

    function automatic int cls_width(input int n_classes);
        return (n_classes > 1) ? $clog2(n_classes) : 1;
    endfunction

    function automatic int acc_width(input int data_w, input int n_feat);
        return 2 * data_w + $clog2(n_feat);
    endfunction

endpackage

// File: rtl/fmc_mac_lane.sv
// Two-stage signed MAC: registered product, then accumulate.
module fmc_mac_lane #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 24
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic                     in_first,
    input  logic                     in_last,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic                     sum_valid,
    output logic signed [ACC_W-1:0]  acc
);

    localparam int PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] prod_q;
    logic signed [ACC_W-1:0]  prod_ext;
    logic                     v1_q;
    logic                     f1_q;
    logic                     l1_q;

    assign prod_ext = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
            v1_q   <= 1'b0;
            f1_q   <= 1'b0;
            l1_q   <= 1'b0;
        end else begin
            prod_q <= a * b;
            v1_q   <= in_valid;
            f1_q   <= in_first;
            l1_q   <= in_last;
        end
    end

    // First term of a class reloads instead of adding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            sum_valid <= 1'b0;
        end else begin
            sum_valid <= v1_q && l1_q;
            if (v1_q) begin
                acc <= f1_q ? prod_ext : acc + prod_ext;
            end
        end
    end

endmodule

// File: rtl/feature_mac_classifier.sv
// Feature/weight buffers, MAC sequencing FSM and argmax tracking.
module feature_mac_classifier
    import fmc_pkg::*;
#(
    parameter int N_FEAT    = 136,
    parameter int DATA_W    = 8,
    parameter int N_CLASSES = 4,
    parameter int IDX_W     = $clog2(N_FEAT),
    parameter int CLS_W     = cls_width(N_CLASSES),
    parameter int ACC_W     = acc_width(DATA_W, N_FEAT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    feat_wr,
    input  logic [IDX_W-1:0]        feat_index,
    input  logic [DATA_W-1:0]       feat_data,
    input  logic                    wt_wr,
    input  logic [CLS_W-1:0]        wt_class,
    input  logic [IDX_W-1:0]        wt_index,
    input  logic [DATA_W-1:0]       wt_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [CLS_W-1:0]        out_class,
    output logic signed [ACC_W-1:0] out_score,
    output logic                    load_err
);

    fmc_state_t state_q, state_d;

    logic [IDX_W-1:0]  idx_q;
    logic [CLS_W-1:0]  cls_q;
    logic              drain_q;
    logic [DATA_W-1:0] feat_mem [N_FEAT];
    logic [DATA_W-1:0] wt_mem   [N_CLASSES][N_FEAT];

    logic start_ok;
    logic feat_ok;
    logic wt_ok;
    logic wr_err;
    logic idx_last;
    logic cls_last;

    // Start is refused while the previous done pulse is still visible
    assign start_ok = (state_q == IDLE) && start && !done;
    assign feat_ok  = feat_wr && (state_q == IDLE)
                    && (int'(feat_index) < N_FEAT);
    assign wt_ok    = wt_wr && (state_q == IDLE)
                    && (int'(wt_index) < N_FEAT)
                    && (int'(wt_class) < N_CLASSES);
    assign wr_err   = (feat_wr && !feat_ok) || (wt_wr && !wt_ok);
    assign idx_last = idx_q == IDX_W'(N_FEAT - 1);
    assign cls_last = cls_q == CLS_W'(N_CLASSES - 1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok) state_d = RUN;
            RUN:     if (idx_last && cls_last) state_d = DRAIN;
            DRAIN:   if (drain_q) state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cls_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == DRAIN) && !drain_q;
            if (start_ok) begin
                idx_q <= '0;
                cls_q <= '0;
            end else if (state_q == RUN) begin
                if (idx_last) begin
                    idx_q <= '0;
                    cls_q <= cls_q + CLS_W'(1);
                end else begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (feat_ok) feat_mem[feat_index] <= feat_data;
        if (wt_ok)   wt_mem[wt_class][wt_index] <= wt_data;
    end

    logic                    sum_valid;
    logic signed [ACC_W-1:0] lane_acc;

    fmc_mac_lane #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_lane (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (state_q == RUN),
        .in_first  (idx_q == '0),
        .in_last   (idx_last),
        .a         (feat_mem[idx_q]),
        .b         (wt_mem[cls_q][idx_q]),
        .sum_valid (sum_valid),
        .acc       (lane_acc)
    );

    logic [CLS_W-1:0]        sum_cls;
    logic [CLS_W-1:0]        best_cls;
    logic signed [ACC_W-1:0] best_score;
    logic                    take;

    // Strict compare keeps the lower class on ties
    assign take = sum_valid
                && ((sum_cls == '0) || (lane_acc > best_score));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_cls    <= '0;
            best_cls   <= '0;
            best_score <= '0;
        end else if (start_ok) begin
            sum_cls <= '0;
        end else if (sum_valid) begin
            sum_cls <= sum_cls + CLS_W'(1);
            if (take) begin
                best_cls   <= sum_cls;
                best_score <= lane_acc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            out_class <= '0;
            out_score <= '0;
            load_err  <= 1'b0;
        end else begin
            busy     <= (state_q == RUN) || (state_q == DRAIN);
            done     <= state_q == FIN;
            load_err <= (start_ok ? 1'b0 : load_err) | wr_err;
            if (state_q == FIN) begin
                out_class <= best_cls;
                out_score <= best_score;
            end
        end
    end

endmodule

// File: tb/tb_feature_mac_classifier.sv
// Scoreboard bench: directed loads, expected results queued at start.
module tb_feature_mac_classifier;

    localparam int LAT = 547;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              feat_wr;
    logic [7:0]        feat_index;
    logic [7:0]        feat_data;
    logic              wt_wr;
    logic [1:0]        wt_class;
    logic [7:0]        wt_index;
    logic [7:0]        wt_data;
    logic              start;
    logic              busy;
    logic              done;
    logic [1:0]        out_class;
    logic signed [23:0] out_score;
    logic              load_err;

    feature_mac_classifier dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .feat_wr    (feat_wr),
        .feat_index (feat_index),
        .feat_data  (feat_data),
        .wt_wr      (wt_wr),
        .wt_class   (wt_class),
        .wt_index   (wt_index),
        .wt_data    (wt_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .out_class  (out_class),
        .out_score  (out_score),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int cls;
        int score;
        int t0;
    } exp_t;

    exp_t sb[$];
    exp_t em;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    bit   probe_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                em = sb.pop_front();
                chk("out_class", out_class, em.cls);
                chk("out_score", out_score, em.score);
                chk("latency", cyc - em.t0, LAT);
                chk("busy_at_done", busy, 0);
            end
        end
        if (probe_en && dut.u_lane.sum_valid && dut.sum_cls == 2'd1)
            chk("cls1_sum", $signed(dut.u_lane.acc), -2210816);
    end

    task automatic load(input logic [7:0] fv, input logic [7:0] w0,
                        input logic [7:0] w1, input logic [7:0] w2,
                        input logic [7:0] w3);
        logic [7:0] w [4];
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 136; i++) begin
                @(negedge clk);
                wt_wr      = 1'b1;
                wt_class   = 2'(c);
                wt_index   = 8'(i);
                wt_data    = w[c];
                feat_wr    = (c == 0);
                feat_index = 8'(i);
                feat_data  = fv;
            end
        end
        @(negedge clk);
        wt_wr   = 1'b0;
        feat_wr = 1'b0;
    endtask

    task automatic start_inf(input int c, input int s, input bit push);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (push) sb.push_back('{c, s, cyc});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!done && k < 700) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0;
        feat_wr = 1'b0; feat_index = '0; feat_data = '0;
        wt_wr = 1'b0; wt_class = '0; wt_index = '0; wt_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", load_err, 0);
        chk("rst_class", out_class, 0);
        chk("rst_score", out_score, 0);
        rst_n = 1'b1;

        // Single active class
        load(8'h7f, 8'h01, 8'h00, 8'h00, 8'h00);
        start_inf(0, 17272, 1);
        @(negedge clk);
        chk("busy_run", busy, 1);
        wait_done();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse", done, 0);
        @(negedge clk);
        chk("start_at_done_ignored", busy, 0);

        // Negative features, mixed-sign weights
        load(8'h80, 8'h00, 8'h7f, 8'h80, 8'h00);
        probe_en = 1'b1;
        start_inf(2, 2228224, 1);
        wait_done();
        probe_en = 1'b0;

        // Tie between classes 1 and 3
        load(8'h01, 8'h00, 8'h7f, 8'h00, 8'h7f);
        start_inf(1, 17272, 1);
        wait_done();

        // Out-of-range writes
        @(negedge clk);
        feat_wr = 1'b1; feat_index = 8'd136; feat_data = 8'h55;
        wt_wr = 1'b1; wt_class = 2'd1; wt_index = 8'd200;
        wt_data = 8'h55;
        @(negedge clk);
        feat_wr = 1'b0; wt_wr = 1'b0;
        chk("err_range", load_err, 1);
        start_inf(1, 17272, 1);
        chk("err_cleared", load_err, 0);
        wait_done();

        // Restart attempt and write while busy
        start_inf(1, 17272, 1);
        repeat (100) @(negedge clk);
        start = 1'b1;
        feat_wr = 1'b1; feat_index = 8'd0; feat_data = 8'h7f;
        @(negedge clk);
        start = 1'b0; feat_wr = 1'b0;
        chk("err_busy_wr", load_err, 1);
        chk("busy_mid", busy, 1);
        wait_done();
        chk("err_sticky", load_err, 1);

        // Abort mid-run
        start_inf(0, 0, 0);
        repeat (100) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_score", out_score, 0);
        chk("abort_class", out_class, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_idle", busy, 0);
        start_inf(1, 17272, 1);
        wait_done();

        repeat (5) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
